// File: rtl/match_ctrl_pkg.sv
// Shared encodings for the volleyball match sequencer.
// State codes, serve sides and score width.
package match_pkg;

  localparam int SCORE_W = 5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_RALLY = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic SIDE_L = 1'b0;
  localparam logic SIDE_R = 1'b1;

  typedef logic [SCORE_W-1:0] score_t;

endpackage

// File: rtl/match_ctrl_if.sv
// Bundle between the button/VGA glue and the match sequencer.
// master = glue side, slave = match_ctrl.
interface match_ctrl_if;
  import match_pkg::*;

  logic       start_btn;
  logic       ball_ground;
  logic [9:0] ball_x;
  logic       move_tick;
  logic       round_rst;
  logic       serve_side;
  score_t     score_l;
  score_t     score_r;
  logic [2:0] state;
  logic       game_over;

  modport master (
    output start_btn, ball_ground, ball_x,
    input  move_tick, round_rst, serve_side,
    input  score_l, score_r, state, game_over
  );

  modport slave (
    input  start_btn, ball_ground, ball_x,
    output move_tick, round_rst, serve_side,
    output score_l, score_r, state, game_over
  );

endinterface

// File: rtl/match_ctrl_tick_div.sv
// Free-running divider: tick is high when the count
// sits at DIV-1, once every CLK_HZ/TICK_HZ cycles.
module tick_div #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 30
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == CW'(DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/match_ctrl.sv
// Match sequencer: tick gating, round reset, scoring, serve side.
// Build with MATCH_CTRL_DEUCE_EN to require a two-point lead.
module match_ctrl
  import match_pkg::*;
#(
  parameter int         CLK_HZ            = 100_000_000,
  parameter int         TICK_HZ           = 30,
  parameter int         SERVE_TICKS       = 60,
  parameter int         POINT_PAUSE_TICKS = 45,
  parameter int         WIN_SCORE         = 15,
  parameter logic [9:0] NET_X             = 10'd160
) (
  input  logic         clk,
  input  logic         rst,
  match_ctrl_if.slave  bus
);

  localparam int PH_MAX = (SERVE_TICKS > POINT_PAUSE_TICKS) ?
                          SERVE_TICKS : POINT_PAUSE_TICKS;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam score_t WIN = score_t'(WIN_SCORE);

  logic            raw_tick;
  logic [2:0]      state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  score_t          score_l_q, score_l_d;
  score_t          score_r_q, score_r_d;
  logic            side_q, side_d;
  logic            decided_q, decided_d;
  logic            rr_q, rr_d;
  logic            mt_q, mt_d;
  logic            go_q, go_d;

  tick_div #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .tick (raw_tick)
  );

  logic   scorer_l;
  score_t new_l, new_r, new_s;
  logic   fold, win;

  assign scorer_l = (bus.ball_x >= NET_X);
  assign new_l    = scorer_l ? score_l_q + score_t'(1) : score_l_q;
  assign new_r    = scorer_l ? score_r_q : score_r_q + score_t'(1);
  assign new_s    = scorer_l ? new_l : new_r;

`ifdef MATCH_CTRL_DEUCE_EN
  score_t new_o;
  assign new_o = scorer_l ? new_r : new_l;
  // Equal scores at or past WIN fold back so they never grow unbounded
  assign fold  = (new_l == new_r) && (new_l >= WIN);
  assign win   = (new_s >= WIN) &&
                 ({1'b0, new_s} >= {1'b0, new_o} + 6'd2);
`else
  assign fold  = 1'b0;
  assign win   = (new_s >= WIN);
`endif

  logic start_ok, serve_tk, rally_gnd, point_tk;

  assign start_ok  = bus.start_btn &&
                     (state_q == ST_IDLE || state_q == ST_OVER);
  assign serve_tk  = (state_q == ST_SERVE) && raw_tick;
  assign rally_gnd = (state_q == ST_RALLY) && bus.ball_ground;
  assign point_tk  = (state_q == ST_POINT) && raw_tick;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    side_d    = side_q;
    decided_d = decided_q;
    rr_d      = 1'b0;
    mt_d      = (state_q == ST_RALLY) && raw_tick && !bus.ball_ground;
    unique case (1'b1)
      start_ok: begin
        state_d   = ST_SERVE;
        phase_d   = PH_W'(SERVE_TICKS);
        score_l_d = '0;
        score_r_d = '0;
        side_d    = SIDE_L;
        decided_d = 1'b0;
        rr_d      = 1'b1;
      end
      serve_tk: begin
        if (phase_q == PH_W'(1)) state_d = ST_RALLY;
        else                     phase_d = phase_q - PH_W'(1);
      end
      rally_gnd: begin
        state_d   = ST_POINT;
        phase_d   = PH_W'(POINT_PAUSE_TICKS);
        side_d    = scorer_l ? SIDE_L : SIDE_R;
        score_l_d = fold ? WIN - score_t'(1) : new_l;
        score_r_d = fold ? WIN - score_t'(1) : new_r;
        decided_d = win;
      end
      point_tk: begin
        if (phase_q != PH_W'(1)) begin
          phase_d = phase_q - PH_W'(1);
        end else if (decided_q) begin
          state_d = ST_OVER;
        end else begin
          state_d = ST_SERVE;
          phase_d = PH_W'(SERVE_TICKS);
          rr_d    = 1'b1;
        end
      end
      default: ;
    endcase
    go_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
      side_q    <= SIDE_L;
      decided_q <= 1'b0;
      rr_q      <= 1'b0;
      mt_q      <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      side_q    <= side_d;
      decided_q <= decided_d;
      rr_q      <= rr_d;
      mt_q      <= mt_d;
      go_q      <= go_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.score_l    = score_l_q;
  assign bus.score_r    = score_r_q;
  assign bus.serve_side = side_q;
  assign bus.round_rst  = rr_q;
  assign bus.move_tick  = mt_q;
  assign bus.game_over  = go_q;

endmodule

// File: doc/match_ctrl.md
# match_ctrl

Match sequencer for the two-player volleyball game. It divides the system clock into the 30 Hz physics tick and gates that tick to the player and ball blocks, so the field only moves during a rally. It pulses a round reset that returns players and ball to their serve positions, and detects ball touchdown to keep score and serve side. It sits between the top-level button/VGA glue and the player, ball and score-display blocks.

## Interface
- CLK_HZ, 100_000_000: system clock frequency.
- TICK_HZ, 30: physics tick rate; DIV = CLK_HZ/TICK_HZ.
- SERVE_TICKS, 60: raw ticks of frozen countdown before each rally (≥1).
- POINT_PAUSE_TICKS, 45: raw ticks of freeze after a point (≥1).
- WIN_SCORE, 15: points needed to win (2..30).
- NET_X, 10'd160: ball_x ≥ NET_X is the right half.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start_btn  in  1  debounced one-cycle start pulse.
- ball_ground  in  1  level; ball is touching the floor.
- ball_x  in  10  ball x position.
- move_tick  out  1  gated physics tick to players and ball.
- round_rst  out  1  one-cycle pulse; players and ball reload their serve positions.
- serve_side  out  1  0 = left serves, 1 = right serves.
- score_l, score_r  out  5  scores.
- state  out  3  current state encoding.
- game_over  out  1  high in OVER.

## Operation
- Free-running divider div_cnt counts 0..DIV-1 and wraps. raw_tick = (div_cnt == DIV-1).
- States: IDLE, SERVE, RALLY, POINT, OVER.
- IDLE: on start_btn, go to SERVE, clear both scores, set serve_side=0, assert round_rst.
- SERVE: phase_cnt is loaded with SERVE_TICKS on entry. On each raw_tick, if phase_cnt==1 go to RALLY, else decrement.
- RALLY: ball_ground is sampled every clock. When it is high:
  - ball_x ≥ NET_X: left scores. Otherwise right scores.
  - serve_side is set to the scoring side.
  - Go to POINT with phase_cnt=POINT_PAUSE_TICKS.
  - Latch decided = (scorer's new score ≥ WIN_SCORE).
- POINT: count down as in SERVE. At expiry go to OVER if decided, else go to SERVE and assert round_rst.
- OVER: game_over=1 and scores are held. On start_btn, behave exactly as IDLE+start_btn.
- start_btn is ignored in SERVE, RALLY and POINT.
- Scores are 5-bit unsigned and never wrap; WIN_SCORE ≤ 30 guarantees this.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, div_cnt=0, phase_cnt=0, move_tick=0, round_rst=0, serve_side=0, scores=0, game_over=0, decided=0.
- Reset has priority over every other input. Reset during any state aborts the match.
- move_tick is high for one cycle, on the clock after raw_tick, when state==RALLY in the raw_tick cycle and ball_ground is low in that cycle.
  - ball_ground and raw_tick in the same RALLY cycle: the point is scored and no move_tick is issued.
- round_rst is high for exactly one cycle, coincident with the first cycle state==SERVE.
- The transition out of SERVE happens on a raw_tick, which is gated. The first move_tick therefore follows the next raw_tick, exactly DIV cycles later.
- Score update, serve_side update and the state change to POINT occur on the same edge, one cycle after ball_ground is sampled.
- div_cnt is never reset by state changes. Phase lengths are exact counts of raw ticks, so the first tick may be a partial period.

## Configuration
- MATCH_CTRL_DEUCE_EN defined: a win requires score ≥ WIN_SCORE and a lead ≥ 2.
  - When a point makes the scores equal and ≥ WIN_SCORE, both scores are set to WIN_SCORE-1 on that same edge (deuce fold).
  - This keeps scores ≤ WIN_SCORE+1.
- Undefined: the first side to reach WIN_SCORE wins.

## Structure
- match_pkg holds:
  - State encodings ST_IDLE=0, ST_SERVE=1, ST_RALLY=2, ST_POINT=3, ST_OVER=4.
  - SIDE_L=0 and SIDE_R=1.
  - Score width SCORE_W=5.
- Sub-module tick_div (parameters CLK_HZ, TICK_HZ; ports clk, rst, tick). It produces raw_tick and is reusable by the display blink logic.
- The FSM, phase counter and score logic stay in match_ctrl.

## Test plan
All scenarios use CLK_HZ=300, TICK_HZ=30 (DIV=10), SERVE_TICKS=3, POINT_PAUSE_TICKS=2, WIN_SCORE=3, NET_X=160.
- Reset, then start_btn → round_rst is a single pulse. No move_tick for 3 raw ticks. move_tick then pulses every 10 cycles while ball_ground is low.
- RALLY, ball_ground=1 with ball_x=100 → next edge: score_r=1, serve_side=1, state=POINT. Then SERVE after 2 raw ticks, with a round_rst pulse.
- ball_ground=1 with ball_x=160 → left scores (boundary).
- ball_ground asserted in the same cycle as raw_tick during RALLY → no move_tick, point counted once.
- Right scores 3 straight points (no deuce) → after the third POINT pause, state=OVER and game_over=1. start_btn clears the scores, returns to SERVE and pulses round_rst.
- With MATCH_CTRL_DEUCE_EN: reach 2-2, left scores, then right scores → scores fold to 2-2. Left then scores twice → 4-2 and OVER. Also assert rst mid-RALLY → all outputs return to reset values on the next edge.
